// File: rtl/servo_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM generator.
package servo_pkg;

    localparam int unsigned US_PER_S = 1_000_000;

    localparam int unsigned DEF_CLK_HZ    = 25_000_000;
    localparam int unsigned DEF_N_CH      = 2;
    localparam int unsigned DEF_FRAME_US  = 20_000;
    localparam int unsigned DEF_MIN_US    = 1_000;
    localparam int unsigned DEF_SPAN_US   = 1_000;
    localparam int unsigned DEF_POS_W     = 10;
    localparam int unsigned DEF_HB_FRAMES = 25;
    localparam int unsigned DEF_SLEW_STEP = 10;

    // Out-of-range positions saturate at the span limit rather than wrapping.
    function automatic int unsigned pos_clamp(input int unsigned pos, input int unsigned span);
        return (pos > span) ? span : pos;
    endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One servo channel: shadow/active position registers, optional slew limiter
// (SERVO_SLEW_EN) and the registered pulse comparator.
module servo_pwm_ch
    import servo_pkg::*;
#(
    parameter int unsigned MIN_US    = DEF_MIN_US,
    parameter int unsigned SPAN_US   = DEF_SPAN_US,
    parameter int unsigned POS_W     = DEF_POS_W,
`ifdef SERVO_SLEW_EN
    parameter int unsigned SLEW_STEP = DEF_SLEW_STEP,
`endif
    parameter int unsigned US_W      = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fs,
    input  logic             wr,
    input  logic [POS_W-1:0] wr_pos,
    input  logic [US_W-1:0]  us_cnt,
    output logic             pwm
);

    localparam logic [POS_W-1:0] CENTRE = POS_W'(SPAN_US / 2);

    logic [POS_W-1:0] shadow_q, shadow_d;
    logic [POS_W-1:0] active_q, active_d;
    logic             pwm_q, pwm_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        shadow_d = shadow_q;
        if (wr) begin
            shadow_d = POS_W'(pos_clamp(32'(wr_pos), SPAN_US));
        end
    end

`ifdef SERVO_SLEW_EN
    always_comb begin
        active_d = active_q;
        if (fs) begin
            if (shadow_q > active_q) begin
                active_d = (32'(shadow_q) - 32'(active_q) > SLEW_STEP)
                         ? POS_W'(32'(active_q) + SLEW_STEP) : shadow_q;
            end else if (shadow_q < active_q) begin
                active_d = (32'(active_q) - 32'(shadow_q) > SLEW_STEP)
                         ? POS_W'(32'(active_q) - SLEW_STEP) : shadow_q;
            end
        end
    end
`else
    always_comb begin
        active_d = active_q;
        if (fs) begin
            active_d = shadow_q;
        end
    end
`endif

    // During the FS cycle us_cnt is 0, so the old active value still yields a high bit.
    always_comb begin
        pwm_d = (32'(us_cnt) < MIN_US + 32'(active_q));
    end

    // NOTE: the position registers are reset (to centre) because they set the servo's power-up position.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= CENTRE;
            active_q <= CENTRE;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel 50 Hz servo PWM generator with frame-aligned position updates
// and a frame-rate heartbeat LED. Optional slew limiting: define SERVO_SLEW_EN.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
    parameter int unsigned N_CH      = DEF_N_CH,
    parameter int unsigned FRAME_US  = DEF_FRAME_US,
    parameter int unsigned MIN_US    = DEF_MIN_US,
    parameter int unsigned SPAN_US   = DEF_SPAN_US,
    parameter int unsigned POS_W     = DEF_POS_W,
    parameter int unsigned HB_FRAMES = DEF_HB_FRAMES,
    parameter int unsigned SLEW_STEP = DEF_SLEW_STEP,
    localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [POS_W-1:0] wr_pos,
    output logic [N_CH-1:0]  servo_pwm,
    output logic             frame_tick,
    output logic             led_hb,
    output logic             wr_err
);

    localparam int unsigned PRE_DIV = CLK_HZ / US_PER_S;
    localparam int unsigned PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam int unsigned US_W    = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
    localparam int unsigned HB_W    = (HB_FRAMES > 1) ? $clog2(HB_FRAMES) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [US_W-1:0]  us_q, us_d;
    logic [HB_W-1:0]  hb_q, hb_d;
    logic             led_q, led_d;
    logic             frame_tick_q, frame_tick_d;
    logic             wr_err_q, wr_err_d;
    logic             fs;
    logic             us_wrap;
    logic [N_CH-1:0]  ch_wr;

    assign fs      = (pre_q == '0) && (us_q == '0);
    assign us_wrap = (pre_q == PRE_W'(PRE_DIV - 1));

    always_comb begin
        pre_d = us_wrap ? '0 : pre_q + 1'b1;
        us_d  = us_q;
        if (us_wrap) begin
            us_d = (us_q == US_W'(FRAME_US - 1)) ? '0 : us_q + 1'b1;
        end
    end

    always_comb begin
        hb_d  = hb_q;
        led_d = led_q;
        if (fs) begin
            if (hb_q == HB_W'(HB_FRAMES - 1)) begin
                hb_d  = '0;
                led_d = ~led_q;
            end else begin
                hb_d = hb_q + 1'b1;
            end
        end
    end

    // Out-of-range channel numbers match no decode bit, so they only raise wr_err.
    always_comb begin
        ch_wr = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            ch_wr[i] = wr_en && (32'(wr_ch) == 32'(i));
        end
        wr_err_d     = wr_en && (32'(wr_ch) >= N_CH);
        frame_tick_d = fs;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q        <= '0;
            us_q         <= '0;
            hb_q         <= '0;
            led_q        <= 1'b0;
            frame_tick_q <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            us_q         <= us_d;
            hb_q         <= hb_d;
            led_q        <= led_d;
            frame_tick_q <= frame_tick_d;
            wr_err_q     <= wr_err_d;
        end
    end

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
        servo_pwm_ch #(
            .MIN_US    (MIN_US),
            .SPAN_US   (SPAN_US),
            .POS_W     (POS_W),
`ifdef SERVO_SLEW_EN
            .SLEW_STEP (SLEW_STEP),
`endif
            .US_W      (US_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .fs     (fs),
            .wr     (ch_wr[g]),
            .wr_pos (wr_pos),
            .us_cnt (us_q),
            .pwm    (servo_pwm[g])
        );
    end

    assign frame_tick = frame_tick_q;
    assign led_hb     = led_q;
    assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi using scaled-down timing (2 cycles/us, 100 us frame).
module tb_servo_pwm_multi;

    localparam int unsigned CLK_HZ    = 2_000_000;
    localparam int unsigned N_CH      = 3;
    localparam int unsigned FRAME_US  = 100;
    localparam int unsigned MIN_US    = 20;
    localparam int unsigned SPAN_US   = 40;
    localparam int unsigned POS_W     = 6;
    localparam int unsigned HB_FRAMES = 3;
    localparam int          CH_W      = 2;
    localparam int          FRAME_CYC = 200;
    localparam int          N_VEC     = 14;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [POS_W-1:0] wr_pos;
    logic [N_CH-1:0]  servo_pwm;
    logic             frame_tick;
    logic             led_hb;
    logic             wr_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    servo_pwm_multi #(
        .CLK_HZ    (CLK_HZ),
        .N_CH      (N_CH),
        .FRAME_US  (FRAME_US),
        .MIN_US    (MIN_US),
        .SPAN_US   (SPAN_US),
        .POS_W     (POS_W),
        .HB_FRAMES (HB_FRAMES),
        .SLEW_STEP (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_pos     (wr_pos),
        .servo_pwm  (servo_pwm),
        .frame_tick (frame_tick),
        .led_hb     (led_hb),
        .wr_err     (wr_err)
    );

    // wr_at: 0 = no write, 1 = write in first cycle of the frame, 2 = write in the FS cycle ending it.
    // w0..w2 are the expected high-cycle counts of the frame the row is applied in.
    typedef struct {
        int               wr_at;
        logic [CH_W-1:0]  ch;
        logic [POS_W-1:0] pos;
        int               w0;
        int               w1;
        int               w2;
        int               errs;
    } vec_t;

    vec_t vecs[N_VEC];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ft(output int lat);
        bit found = 1'b0;
        lat = 0;
        while (!found && lat < 2 * FRAME_CYC) begin
            @(negedge clk);
            lat++;
            if (frame_tick) found = 1'b1;
        end
        if (!found) lat = -1;
    endtask

    // Starts at a negedge where frame_tick is high; ends at the next such negedge.
    task automatic run_frame(input int wr_at, input logic [CH_W-1:0] ch, input logic [POS_W-1:0] pos,
                             output int w0, output int w1, output int w2, output int per, output int errs);
        w0 = 0; w1 = 0; w2 = 0; per = 0; errs = 0;
        do begin
            w0   += int'(servo_pwm[0]);
            w1   += int'(servo_pwm[1]);
            w2   += int'(servo_pwm[2]);
            errs += int'(wr_err);
            per++;
            wr_en  = (wr_at == 1 && per == 1) || (wr_at == 2 && per == FRAME_CYC);
            wr_ch  = ch;
            wr_pos = pos;
            @(negedge clk);
        end while (!frame_tick && per < 2 * FRAME_CYC);
        wr_en = 1'b0;
    endtask

    initial begin
        int lat, w0, w1, w2, per, errs, fs_count;

        // Cycles per us = 2; centre = 20 -> 40 us -> 80 cycles; pos 0 -> 40; pos 40 -> 120.
        vecs[0]  = '{0, 2'd0, 6'd0,  80,  80,  80, 0};
        vecs[1]  = '{1, 2'd1, 6'd0,  80,  80,  80, 0};
        vecs[2]  = '{0, 2'd0, 6'd0,  80,  40,  80, 0};
        vecs[3]  = '{1, 2'd0, 6'd63, 80,  40,  80, 0};
        vecs[4]  = '{0, 2'd0, 6'd0,  120, 40,  80, 0};
        vecs[5]  = '{1, 2'd3, 6'd0,  120, 40,  80, 1};
        vecs[6]  = '{0, 2'd0, 6'd0,  120, 40,  80, 0};
        vecs[7]  = '{1, 2'd2, 6'd40, 120, 40,  80, 0};
        vecs[8]  = '{0, 2'd0, 6'd0,  120, 40,  120, 0};
        vecs[9]  = '{1, 2'd0, 6'd1,  120, 40,  120, 0};
        vecs[10] = '{0, 2'd0, 6'd0,  42,  40,  120, 0};
        vecs[11] = '{2, 2'd1, 6'd10, 42,  40,  120, 0};
        vecs[12] = '{0, 2'd0, 6'd0,  42,  40,  120, 0};
        vecs[13] = '{0, 2'd0, 6'd0,  42,  60,  120, 0};

        rst_n  = 1'b0;
        wr_en  = 1'b0;
        wr_ch  = '0;
        wr_pos = '0;
        repeat (3) @(negedge clk);
        check("reset servo_pwm", int'(servo_pwm), 0);
        check("reset frame_tick", int'(frame_tick), 0);
        check("reset led_hb", int'(led_hb), 0);
        check("reset wr_err", int'(wr_err), 0);

        rst_n = 1'b1;
        wait_ft(lat);
        check("first FS latency", lat, 1);
        if (lat < 0) begin
            $display("FAIL no frame_tick after reset release");
            $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
            $fatal(1);
        end

        fs_count = 1;
        for (int i = 0; i < N_VEC; i++) begin
            check($sformatf("vec%0d led_hb", i), int'(led_hb), (fs_count / int'(HB_FRAMES)) % 2);
            run_frame(vecs[i].wr_at, vecs[i].ch, vecs[i].pos, w0, w1, w2, per, errs);
            check($sformatf("vec%0d ch0 width", i), w0, vecs[i].w0);
            check($sformatf("vec%0d ch1 width", i), w1, vecs[i].w1);
            check($sformatf("vec%0d ch2 width", i), w2, vecs[i].w2);
            check($sformatf("vec%0d frame period", i), per, FRAME_CYC);
            check($sformatf("vec%0d wr_err pulses", i), errs, vecs[i].errs);
            fs_count++;
        end

        // Reset in the middle of a high pulse, then recovery to centre widths.
        repeat (10) @(negedge clk);
        check("pre-reset pulses high", int'(servo_pwm), 7);
        check("pre-reset led_hb", int'(led_hb), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid-pulse reset servo_pwm", int'(servo_pwm), 0);
        check("mid-pulse reset led_hb", int'(led_hb), 0);
        check("mid-pulse reset frame_tick", int'(frame_tick), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ft(lat);
        check("re-release FS latency", lat, 1);
        if (lat >= 0) begin
            run_frame(0, '0, '0, w0, w1, w2, per, errs);
            check("post-reset ch0 width", w0, 80);
            check("post-reset ch1 width", w1, 80);
            check("post-reset ch2 width", w2, 80);
            check("post-reset frame period", per, FRAME_CYC);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
